// File: rtl/low_freq_generator.sv
// Square-wave tone generator: BCD Hz -> binary -> period_us = floor(1e6/f) -> square wave.
// Latency: o_done and first o_wave high 25 cycles after the cycle sampling i_start.
// Backpressure: none; i_start/i_stop are ignored while converting or dividing.
module low_freq_generator #(
  parameter int CLK_FREQ_MHZ = 100
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic [3:0][3:0] i_freq_bcd,
  output logic            o_wave,
  output logic            o_ready,
  output logic            o_running,
  output logic            o_done,
  output logic            o_error,
  output logic [19:0]     o_period_us
);

  localparam int US_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [US_W-1:0] US_MAX = US_W'(CLK_FREQ_MHZ - 1);
  localparam logic [19:0] DIVIDEND = 20'd1_000_000;

  typedef enum logic [1:0] {e_idle, e_bcd_convert, e_divide, e_run} state_t;

  state_t          state, state_nxt;
  logic [3:0][3:0] digits;
  logic [1:0]      digit_idx;
  logic [4:0]      bit_cnt;
  logic [13:0]     acc, acc_nxt;
  logic [3:0]      cur_digit;
  logic [19:0]     rem, quo, rem_nxt, quo_nxt;
  logic [20:0]     trial;
  logic            q_bit;
  logic [19:0]     half_hi, half_lo, phase, cur_len;
  logic [US_W-1:0] us_cnt;
  logic            us_tick, phase_end, wave_lvl;
  logic            bad_digit, start_ok;

  // Command decode, BCD accumulate step, one restoring-divide step and timebase compares.
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (i_freq_bcd[k] > 4'd9) bad_digit = 1'b1;
    end
    start_ok  = i_start && !i_stop;
    cur_digit = digits[2'd3 - digit_idx];
    acc_nxt   = acc * 14'd10 + {10'd0, cur_digit};
    trial     = {rem, quo[19]};
    q_bit     = (trial >= {7'd0, acc});
    rem_nxt   = q_bit ? 20'(trial - {7'd0, acc}) : trial[19:0];
    quo_nxt   = {quo[18:0], q_bit};
    us_tick   = (us_cnt == US_MAX);
    cur_len   = wave_lvl ? half_hi : half_lo;
    phase_end = (phase == cur_len - 20'd1);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= e_idle;
    else          state <= state_nxt;
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_nxt = state;
    o_ready   = (state == e_idle);
    o_running = (state == e_run);
    o_wave    = (state == e_run) && wave_lvl;
    case (state)
      e_idle:        if (start_ok && !bad_digit) state_nxt = e_bcd_convert;
      e_bcd_convert: if (digit_idx == 2'd3) state_nxt = (acc_nxt == 14'd0) ? e_idle : e_divide;
      e_divide:      if (bit_cnt == 5'd19) state_nxt = e_run;
      e_run: begin
        if (i_stop)       state_nxt = e_idle;
        else if (i_start) state_nxt = bad_digit ? e_idle : e_bcd_convert;
      end
      default:       state_nxt = e_idle;
    endcase
  end

  // Datapath: digit latch, BCD accumulator, divider, period/half registers and wave timebase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      digits      <= '0;
      digit_idx   <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      rem         <= '0;
      quo         <= '0;
      half_hi     <= '0;
      half_lo     <= '0;
      phase       <= '0;
      us_cnt      <= '0;
      wave_lvl    <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_period_us <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        e_idle, e_run: begin
          if (start_ok) begin
            digits    <= i_freq_bcd;
            o_error   <= bad_digit;
            acc       <= '0;
            digit_idx <= '0;
          end else if (state == e_run && !i_stop) begin
            // Microsecond timebase drives the per-half phase counter.
            us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
            if (us_tick) begin
              if (phase_end) begin
                phase    <= '0;
                wave_lvl <= !wave_lvl;
              end else begin
                phase <= phase + 20'd1;
              end
            end
          end
        end
        e_bcd_convert: begin
          acc       <= acc_nxt;
          digit_idx <= digit_idx + 2'd1;
          if (digit_idx == 2'd3) begin
            if (acc_nxt == 14'd0) begin
              o_error <= 1'b1;
            end else begin
              rem     <= '0;
              quo     <= DIVIDEND;
              bit_cnt <= '0;
            end
          end
        end
        e_divide: begin
          rem     <= rem_nxt;
          quo     <= quo_nxt;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd19) begin
            // Wave starts high in the first run cycle; odd periods put the extra us in the low half.
            o_period_us <= quo_nxt;
            half_hi     <= quo_nxt >> 1;
            half_lo     <= quo_nxt - (quo_nxt >> 1);
            o_done      <= 1'b1;
            us_cnt      <= '0;
            phase       <= '0;
            wave_lvl    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_low_freq_generator.sv
// Self-checking bench for low_freq_generator: random tones against an arithmetic model.
// Checks latency, period, high/low lengths, error paths, stop/restart and async reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_low_freq_generator;

  localparam int CLK_MHZ = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [3:0][3:0] bcd = '0;
  logic            wave, ready, running, done, error;
  logic [19:0]     period;

  int total = 0;
  int bad = 0;
  int last_period = 0;

  low_freq_generator #(.CLK_FREQ_MHZ(CLK_MHZ)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_freq_bcd(bcd), .o_wave(wave), .o_ready(ready), .o_running(running),
    .o_done(done), .o_error(error), .o_period_us(period)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int f);
    return {4'(f / 1000), 4'((f / 100) % 10), 4'((f / 10) % 10), 4'(f % 10)};
  endfunction

  // Pulse i_start for one cycle; returns at the sample point of cycle 1.
  task automatic pulse_start(input logic [15:0] d);
    @(negedge clk);
    bcd   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_stop(input string tag);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check({tag, "_stop_wave"}, wave, 0);
    check({tag, "_stop_ready"}, ready, 1);
  endtask

  // Start a tone at f Hz and measure nper full periods against the model.
  task automatic run_tone(input int f, input string tag, input int nper);
    int cyc, p, hi, lo, n;
    p  = 1000000 / f;
    hi = p / 2;
    lo = p - hi;
    pulse_start(to_bcd(f));
    wait_done(cyc);
    check({tag, "_lat"}, cyc, 25);
    check({tag, "_per"}, period, p);
    check({tag, "_run"}, running, 1);
    check({tag, "_wave0"}, wave, 1);
    last_period = p;
    for (int k = 0; k < nper; k++) begin
      n = 0;
      while (wave && n < hi * CLK_MHZ + 50) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_hi"}, n, hi * CLK_MHZ);
      n = 0;
      while (!wave && n < lo * CLK_MHZ + 50) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_lo"}, n, lo * CLK_MHZ);
    end
  endtask

  initial begin
    int hits;
    int f;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_wave", wave, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_period", period, 0);
    check("rst_running", running, 0);
    rst_n = 1'b1;

    run_tone(1000, "f1000", 2);
    check("f1000_hi_before_stop", wave, 1);
    do_stop("f1000");
    run_tone(9999, "f9999", 3);
    do_stop("f9999");
    run_tone(3, "f3", 0);
    do_stop("f3");

    for (int i = 0; i < 6; i++) begin
      f = int'($urandom_range(9999, 500));
      run_tone(f, "rnd", 1);
      if (i % 2 == 1) do_stop("rnd");
    end
    do_stop("rnd_end");

    // Zero frequency: error after conversion, period untouched.
    pulse_start(16'h0000);
    check("zero_err_c1", error, 0);
    repeat (4) @(negedge clk);
    check("zero_err_c5", error, 1);
    check("zero_ready", ready, 1);
    check("zero_wave", wave, 0);
    check("zero_period", period, last_period);

    // Non-BCD digit: immediate error, no conversion.
    pulse_start(16'h0A00);
    check("badd_err_c1", error, 1);
    check("badd_ready", ready, 1);
    repeat (5) @(negedge clk);
    check("badd_still_idle", ready, 1);
    check("badd_period", period, last_period);

    run_tone(1000, "clr", 0);
    check("clr_error", error, 0);

    // Start together with stop: stop wins, no restart.
    @(negedge clk);
    bcd   = to_bcd(2000);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("both_ready", ready, 1);
    check("both_wave", wave, 0);
    repeat (30) @(negedge clk);
    check("both_no_restart", ready, 1);
    check("both_period", period, 1000);

    // Restart from run to 50 Hz with an ignored start during divide.
    run_tone(1000, "pre", 0);
    pulse_start(to_bcd(50));
    hits = 0;
    for (int c = 1; c < 25; c++) begin
      if (wave) hits++;
      if (c == 11) begin
        bcd   = to_bcd(9999);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("rs_wave_gap", hits, 0);
    check("rs_done", done, 1);
    check("rs_period", period, 20000);
    do_stop("rs");

    // Async reset during divide.
    pulse_start(to_bcd(1234));
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ready", ready, 1);
    check("ar_period", period, 0);
    check("ar_wave", wave, 0);
    check("ar_done", done, 0);
    check("ar_running", running, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("ar_idle_after", ready, 1);
    check("ar_period_after", period, 0);
    run_tone(9999, "post", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
